// File: rtl/input_debouncer_pkg.sv
// Shared definitions for the input debouncer: debounce state encoding,
// default parameter values and a counter-width helper.
package input_debouncer_pkg;

  // Debounce cell states: STABLE holds the accepted value, ARMING times a candidate.
  typedef enum logic {
    DB_STABLE = 1'b0,
    DB_ARMING = 1'b1
  } db_state_e;

  // 10 ms at 100 MHz for silicon; a short window for simulation.
  localparam int unsigned DB_CYCLES_SYN   = 1_000_000;
  localparam int unsigned DB_CYCLES_SIM   = 4;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned IN_W_DEF        = 8;
  localparam int unsigned MOD_W_DEF       = 3;

  // Stability counter width; counts 0..DB_CYCLES-1, never wraps.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/input_debouncer_cell.sv
// debounce_cell: accepts a new W-bit value only after it has been sampled
// unchanged for DB_CYCLES consecutive clocks; any bit moving restarts timing.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   i_sync       synchronised input word
//   o_q          accepted (debounced) word
//   o_changed    one-clock strobe on the edge o_q takes a new value
module debounce_cell
  import input_debouncer_pkg::*;
#(
  parameter int unsigned W         = 1,
  parameter int unsigned DB_CYCLES = DB_CYCLES_SYN
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_sync,
  output logic [W-1:0] o_q,
  output logic         o_changed
);

  localparam int unsigned       CNT_W    = cnt_width(DB_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);

  db_state_e        r_state;
  logic [W-1:0]     r_cand;
  logic [W-1:0]     r_q;
  logic [CNT_W-1:0] r_cnt;
  logic             r_changed;

  // Debounce FSM; r_cnt holds how many consecutive samples matched r_cand.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= DB_STABLE;
      r_cand    <= '0;
      r_q       <= '0;
      r_cnt     <= '0;
      r_changed <= 1'b0;
    end else begin
      r_changed <= 1'b0;
      case (r_state)
        DB_STABLE: begin
          if (i_sync != r_q) begin
            r_cand  <= i_sync;
            r_cnt   <= CNT_W'(1);
            r_state <= DB_ARMING;
          end else begin
            r_cnt <= '0;
          end
        end
        DB_ARMING: begin
          if (i_sync != r_cand) begin
            // Bounce or another bit moved: restart from this sample.
            r_cand <= i_sync;
            r_cnt  <= CNT_W'(1);
          end else if (r_cand == r_q) begin
            // Settled back on the accepted value: nothing to report.
            r_cnt   <= '0;
            r_state <= DB_STABLE;
          end else if (r_cnt == CNT_LAST) begin
            r_q       <= r_cand;
            r_cnt     <= '0;
            r_changed <= 1'b1;
            r_state   <= DB_STABLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= DB_STABLE;
      endcase
    end
  end

  assign o_q       = r_q;
  assign o_changed = r_changed;

endmodule

// File: rtl/input_debouncer.sv
// input_debouncer: synchronises and debounces the board push-button and the
// switch bank for control_1. The switch bank is debounced as one group so
// control_1 never sees a partially moved {switch, mod, in} word.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   btn_raw              raw push-button (async, bouncy)
//   switch_raw/mod_raw/in_raw  raw switch bank
//   on, on_pulse         debounced button level, rise strobe
//   switch, mod, in      debounced switch group
//   cfg_changed          strobe on each accepted switch-group update
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned DB_CYCLES   = DB_CYCLES_SYN,
  parameter int unsigned IN_W        = IN_W_DEF,
  parameter int unsigned MOD_W       = MOD_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_raw,
  input  logic             switch_raw,
  input  logic [MOD_W-1:0] mod_raw,
  input  logic [IN_W-1:0]  in_raw,
  output logic             on,
  output logic             on_pulse,
  output logic             switch,
  output logic [MOD_W-1:0] mod,
  output logic [IN_W-1:0]  in,
  output logic             cfg_changed
);

  localparam int unsigned G = 1 + MOD_W + IN_W;

  logic [SYNC_STAGES-1:0] r_btn_sync;
  logic [G-1:0]           r_grp_sync [SYNC_STAGES];

  logic                   w_btn_q;
  logic                   w_btn_changed;
  logic [G-1:0]           w_grp_q;
  logic                   w_grp_changed;

  // Synchroniser chains; the switch bank shares one bitwise chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_btn_sync <= '0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        r_grp_sync[i] <= '0;
      end
    end else begin
      r_btn_sync    <= {r_btn_sync[SYNC_STAGES-2:0], btn_raw};
      r_grp_sync[0] <= {switch_raw, mod_raw, in_raw};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_grp_sync[i] <= r_grp_sync[i-1];
      end
    end
  end

  debounce_cell #(
    .W         (1),
    .DB_CYCLES (DB_CYCLES)
  ) u_btn_db (
    .clk       (clk),
    .reset     (reset),
    .i_sync    (r_btn_sync[SYNC_STAGES-1]),
    .o_q       (w_btn_q),
    .o_changed (w_btn_changed)
  );

  debounce_cell #(
    .W         (G),
    .DB_CYCLES (DB_CYCLES)
  ) u_grp_db (
    .clk       (clk),
    .reset     (reset),
    .i_sync    (r_grp_sync[SYNC_STAGES-1]),
    .o_q       (w_grp_q),
    .o_changed (w_grp_changed)
  );

  // q was just loaded from the candidate, so changed & q marks a rise only.
  assign on                 = w_btn_q;
  assign on_pulse           = w_btn_changed & w_btn_q;
  assign {switch, mod, in}  = w_grp_q;
  assign cfg_changed        = w_grp_changed;

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer with SYNC_STAGES=2, DB_CYCLES=4.
// Reference model: a value is accepted once DB_CYCLES consecutive
// synchronised samples agree on it and it differs from the current output.
module tb_input_debouncer;

  localparam int unsigned SYNC  = 2;
  localparam int unsigned DB    = 4;
  localparam int unsigned IN_W  = 8;
  localparam int unsigned MOD_W = 3;
  localparam int unsigned G     = 1 + MOD_W + IN_W;
  localparam int unsigned HL    = SYNC + DB;

  logic             clk = 1'b0;
  logic             reset;
  logic             btn_raw;
  logic             switch_raw;
  logic [MOD_W-1:0] mod_raw;
  logic [IN_W-1:0]  in_raw;
  logic             on_o;
  logic             on_pulse_o;
  logic             switch_o;
  logic [MOD_W-1:0] mod_o;
  logic [IN_W-1:0]  in_o;
  logic             cfg_o;

  input_debouncer #(
    .SYNC_STAGES (SYNC),
    .DB_CYCLES   (DB),
    .IN_W        (IN_W),
    .MOD_W       (MOD_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .switch_raw  (switch_raw),
    .mod_raw     (mod_raw),
    .in_raw      (in_raw),
    .on          (on_o),
    .on_pulse    (on_pulse_o),
    .switch      (switch_o),
    .mod         (mod_o),
    .in          (in_o),
    .cfg_changed (cfg_o)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [G:0]   hist [HL];   // raw samples, [0] = newest edge
  logic         m_on = 1'b0;
  logic         m_on_pulse = 1'b0;
  logic [G-1:0] m_grp = '0;
  logic         m_cfg = 1'b0;

  logic [G+2:0] dut_word;
  logic [G+2:0] exp_word;
  assign dut_word = {on_o, on_pulse_o, switch_o, mod_o, in_o, cfg_o};
  assign exp_word = {m_on, m_on_pulse, m_grp, m_cfg};

  int n_run  = 0;
  int n_fail = 0;

  // Advance one clock edge, update the model with the inputs that edge sampled.
  task automatic tick();
    bit           steady;
    logic         b;
    logic [G-1:0] g;
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < int'(HL); i++) hist[i] = '0;
      m_on = 1'b0; m_on_pulse = 1'b0; m_grp = '0; m_cfg = 1'b0;
    end else begin
      for (int i = int'(HL) - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {btn_raw, switch_raw, mod_raw, in_raw};
      m_on_pulse = 1'b0;
      m_cfg      = 1'b0;
      b = hist[SYNC][G];
      steady = 1'b1;
      for (int j = 0; j < int'(DB); j++) if (hist[int'(SYNC) + j][G] != b) steady = 1'b0;
      if (steady && (b != m_on)) begin
        m_on       = b;
        m_on_pulse = b;
      end
      g = hist[SYNC][G-1:0];
      steady = 1'b1;
      for (int j = 0; j < int'(DB); j++) if (hist[int'(SYNC) + j][G-1:0] != g) steady = 1'b0;
      if (steady && (g != m_grp)) begin
        m_grp = g;
        m_cfg = 1'b1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    int pulses = 0, pulse_at = 0, cfgs = 0, cfg_at = 0;
    reset = 1'b1; btn_raw = 1'b1; switch_raw = 1'b0; mod_raw = 3'b101; in_raw = 8'h00;
    for (int c = 1; c <= 3; c++) begin
      tick();
      n_run++;
      if (dut_word !== '0) begin
        n_fail++; $display("FAIL reset_outputs c=%0d got=%h exp=0", c, dut_word);
      end
    end
    reset = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      n_run++;
      if (dut_word !== exp_word) begin
        n_fail++; $display("FAIL reset_release_model c=%0d got=%h exp=%h", c, dut_word, exp_word);
      end
      if (on_pulse_o === 1'b1) begin pulses++; pulse_at = c; end
      if (cfg_o === 1'b1) begin cfgs++; cfg_at = c; end
    end
    n_run++;
    if (pulses != 1 || pulse_at != 6) begin
      n_fail++; $display("FAIL reset_held_btn pulses=%0d at=%0d exp 1 at 6", pulses, pulse_at);
    end
    n_run++;
    if (cfgs != 1 || cfg_at != 6 || mod_o !== 3'b101 || on_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_switch cfgs=%0d at=%0d mod=%b on=%b exp 1 at 6 101 1",
                         cfgs, cfg_at, mod_o, on_o);
    end
  endtask

  task automatic test_btn_clean();
    int pulses = 0, fall_at = 0, rise_at = 0;
    btn_raw = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      n_run++;
      if (dut_word !== exp_word) begin
        n_fail++; $display("FAIL btn_fall_model c=%0d got=%h exp=%h", c, dut_word, exp_word);
      end
      if (on_pulse_o === 1'b1) pulses++;
      if (on_o === 1'b0 && fall_at == 0) fall_at = c;
    end
    n_run++;
    if (fall_at != 6 || pulses != 0) begin
      n_fail++; $display("FAIL btn_fall at=%0d pulses=%0d exp 6 0", fall_at, pulses);
    end
    btn_raw = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      n_run++;
      if (dut_word !== exp_word) begin
        n_fail++; $display("FAIL btn_rise_model c=%0d got=%h exp=%h", c, dut_word, exp_word);
      end
      if (on_pulse_o === 1'b1) pulses++;
      if (on_o === 1'b1 && rise_at == 0) rise_at = c;
    end
    n_run++;
    if (rise_at != 6 || pulses != 1) begin
      n_fail++; $display("FAIL btn_rise at=%0d pulses=%0d exp 6 1", rise_at, pulses);
    end
  endtask

  task automatic test_bounce();
    logic [3:0] seq = 4'b1010;   // applied msb first: 1,0,1,0
    int pulses = 0, pulse_at = 0;
    btn_raw = 1'b0;
    for (int c = 0; c < 8; c++) tick();
    for (int k = 3; k >= 0; k--) begin
      btn_raw = seq[k];
      tick();
      n_run++;
      if (dut_word !== exp_word) begin
        n_fail++; $display("FAIL bounce_model k=%0d got=%h exp=%h", k, dut_word, exp_word);
      end
      if (on_pulse_o === 1'b1) pulses++;
    end
    btn_raw = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      n_run++;
      if (dut_word !== exp_word) begin
        n_fail++; $display("FAIL bounce_settle_model c=%0d got=%h exp=%h", c, dut_word, exp_word);
      end
      if (on_pulse_o === 1'b1) begin pulses++; pulse_at = c; end
    end
    n_run++;
    if (pulses != 1 || pulse_at != 6) begin
      n_fail++; $display("FAIL bounce_pulse pulses=%0d at=%0d exp 1 at 6", pulses, pulse_at);
    end
  endtask

  task automatic test_short_pulse();
    int highs = 0;
    btn_raw = 1'b0;
    for (int c = 0; c < 8; c++) tick();
    for (int c = 1; c <= 14; c++) begin
      btn_raw = (c <= 3);
      tick();
      n_run++;
      if (dut_word !== exp_word) begin
        n_fail++; $display("FAIL short_model c=%0d got=%h exp=%h", c, dut_word, exp_word);
      end
      if (on_o === 1'b1 || on_pulse_o === 1'b1) highs++;
    end
    n_run++;
    if (highs != 0) begin
      n_fail++; $display("FAIL short_pulse on_or_pulse_cycles=%0d exp 0", highs);
    end
  endtask

  task automatic test_group_coherent();
    int cfgs = 0, cfg_at = 0, partial = 0;
    switch_raw = 1'b0; mod_raw = 3'b000; in_raw = 8'h00;
    for (int c = 0; c < 8; c++) tick();
    in_raw = 8'hA5;
    for (int c = -1; c <= 10; c++) begin
      if (c == 1) mod_raw = 3'b011;
      if (c != 0) begin
        tick();
        n_run++;
        if (dut_word !== exp_word) begin
          n_fail++; $display("FAIL group_model c=%0d got=%h exp=%h", c, dut_word, exp_word);
        end
        if (cfg_o === 1'b1) begin cfgs++; cfg_at = c; end
        if (!({switch_o, mod_o, in_o} === {1'b0, 3'b000, 8'h00} ||
              {switch_o, mod_o, in_o} === {1'b0, 3'b011, 8'hA5})) partial++;
      end
    end
    n_run++;
    if (cfgs != 1 || cfg_at != 6 || partial != 0 || mod_o !== 3'b011 || in_o !== 8'hA5) begin
      n_fail++; $display("FAIL group_update cfgs=%0d at=%0d partial=%0d mod=%b in=%h exp 1 6 0 011 a5",
                         cfgs, cfg_at, partial, mod_o, in_o);
    end
  endtask

  task automatic test_simultaneous();
    int both_at = 0, pulses = 0, cfgs = 0;
    btn_raw = 1'b0;
    for (int c = 0; c < 8; c++) tick();
    btn_raw = 1'b1; mod_raw = 3'b110;
    for (int c = 1; c <= 8; c++) begin
      tick();
      n_run++;
      if (dut_word !== exp_word) begin
        n_fail++; $display("FAIL simul_model c=%0d got=%h exp=%h", c, dut_word, exp_word);
      end
      if (on_pulse_o === 1'b1) pulses++;
      if (cfg_o === 1'b1) cfgs++;
      if (on_pulse_o === 1'b1 && cfg_o === 1'b1 && mod_o === 3'b110) both_at = c;
    end
    n_run++;
    if (both_at != 6 || pulses != 1 || cfgs != 1) begin
      n_fail++; $display("FAIL simul_strobes at=%0d pulses=%0d cfgs=%0d exp 6 1 1", both_at, pulses, cfgs);
    end
  endtask

  task automatic test_reset_mid_arming();
    int pulses = 0, cfgs = 0, cfg_at = 0;
    btn_raw = 1'b0; in_raw = 8'h3C;
    for (int c = 0; c < 3; c++) tick();
    reset = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      tick();
      n_run++;
      if (dut_word !== '0) begin
        n_fail++; $display("FAIL midreset_outputs c=%0d got=%h exp=0", c, dut_word);
      end
    end
    reset = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      n_run++;
      if (dut_word !== exp_word) begin
        n_fail++; $display("FAIL midreset_model c=%0d got=%h exp=%h", c, dut_word, exp_word);
      end
      if (on_pulse_o === 1'b1) pulses++;
      if (cfg_o === 1'b1) begin cfgs++; cfg_at = c; end
    end
    n_run++;
    if (pulses != 0 || cfgs != 1 || cfg_at != 6 ||
        {switch_o, mod_o, in_o} !== {1'b0, 3'b110, 8'h3C} || on_o !== 1'b0) begin
      n_fail++; $display("FAIL midreset_restart pulses=%0d cfgs=%0d at=%0d word=%h on=%b exp 0 1 6 63c 0",
                         pulses, cfgs, cfg_at, {switch_o, mod_o, in_o}, on_o);
    end
  endtask

  task automatic test_random();
    int hold;
    for (int seg = 0; seg < 400; seg++) begin
      reset = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 2) == 0) btn_raw = ~btn_raw;
      if ($urandom_range(0, 3) == 0) begin
        switch_raw = 1'($urandom);
        mod_raw    = MOD_W'($urandom);
        in_raw     = IN_W'($urandom);
      end else if ($urandom_range(0, 3) == 0) begin
        mod_raw[$urandom_range(0, MOD_W - 1)] = ~mod_raw[0];
      end
      hold = $urandom_range(1, 7);
      for (int k = 0; k < hold; k++) begin
        tick();
        n_run++;
        if (dut_word !== exp_word) begin
          n_fail++; $display("FAIL random_model seg=%0d got=%h exp=%h", seg, dut_word, exp_word);
        end
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_btn_clean();
    test_bounce();
    test_short_pulse();
    test_group_coherent();
    test_simultaneous();
    test_reset_mid_arming();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
